// File: rtl/u_dmem_if.sv
// Core data-port and loader bundle for u_dmem. The master drives requests; the slave
// (the memory) returns read data, loader ready and the TOHOST status.
interface u_dmem_if;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;
  logic [31:0] dat_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_a;
  logic [31:0] ld_wd;
  logic        done;
  logic [31:0] tohost;

  modport master (
    output dat_a, dat_we, dat_wd, dat_re, ld_valid, ld_a, ld_wd,
    input  dat_rd, ld_ready, done, tohost
  );

  modport slave (
    input  dat_a, dat_we, dat_wd, dat_re, ld_valid, ld_a, ld_wd,
    output dat_rd, ld_ready, done, tohost
  );
endinterface

// File: rtl/u_dmem.sv
// Data memory with byte-lane access, one-cycle registered reads, an MMIO window at 0xF000
// (TOHOST, CYCLE, SCRATCH) and a loader port that only writes when the core is idle.
module u_dmem #(
  parameter int unsigned DEPTH = 4096
) (
  input logic     clk,
  input logic     rst,
  u_dmem_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    RegTohost  = 2'd0,
    RegCycle   = 2'd1,
    RegScratch = 2'd2,
    RegNone    = 2'd3
  } mmio_reg_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] en);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{en[i]}};
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] m;
    m = lane_mask(we);
    return (old & ~m) | (wd & m);
  endfunction

  logic [31:0] mem [DEPTH];

  logic [31:0] rd_q, rd_d;
  logic [31:0] tohost_q, tohost_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] cycle_q;
  logic        done_q, done_d;

  logic        ld_ready;
  logic        ld_acc;
  logic        core_wr;
  logic [15:0] wr_a;
  logic [3:0]  wr_we;
  logic [31:0] wr_wd;
  logic        wr_mmio, wr_ram_ok, wr_tohost, wr_scratch;
  logic [13:0] wr_word;
  logic [IdxW-1:0] wr_idx;

  logic        rd_mmio, rd_ram_ok, rd_merge;
  logic [13:0] rd_word;
  logic [IdxW-1:0] rd_idx;
  logic [31:0] rd_raw, rd_val;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.dat_a[1:0], bus.ld_a[1:0]};

  assign ld_ready = !rst && (bus.dat_we == 4'h0) && (bus.dat_re == 4'h0);
  assign ld_acc   = bus.ld_valid && ld_ready;
  assign core_wr  = (bus.dat_we != 4'h0);

  // Single write port shared by core and loader; the loader only gets it when the core is idle.
  assign wr_a  = core_wr ? bus.dat_a  : bus.ld_a;
  assign wr_wd = core_wr ? bus.dat_wd : bus.ld_wd;
  assign wr_we = core_wr ? bus.dat_we : (ld_acc ? 4'hF : 4'h0);

  assign wr_mmio    = (wr_a[15:12] == 4'hF);
  assign wr_word    = wr_a[15:2];
  assign wr_idx     = wr_word[IdxW-1:0];
  assign wr_ram_ok  = !wr_mmio && (32'(wr_word) < DEPTH) && (wr_we != 4'h0);
  assign wr_tohost  = wr_mmio && (mmio_reg_e'(wr_a[3:2]) == RegTohost) && (wr_we != 4'h0);
  assign wr_scratch = wr_mmio && (mmio_reg_e'(wr_a[3:2]) == RegScratch) && (wr_we != 4'h0);

  always_ff @(posedge clk) begin
    if (wr_ram_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_we[i]) mem[wr_idx][8*i +: 8] <= wr_wd[8*i +: 8];
      end
    end
  end

  assign rd_mmio   = (bus.dat_a[15:12] == 4'hF);
  assign rd_word   = bus.dat_a[15:2];
  assign rd_idx    = rd_word[IdxW-1:0];
  assign rd_ram_ok = !rd_mmio && (32'(rd_word) < DEPTH);

  // Core reads and writes share dat_a, so a same-cycle write always targets the word being read.
  always_comb begin
    rd_raw   = '0;
    rd_merge = 1'b0;
    if (rd_mmio) begin
      unique case (mmio_reg_e'(bus.dat_a[3:2]))
        RegTohost: begin
          rd_raw   = tohost_q;
          rd_merge = 1'b1;
        end
        RegCycle:  rd_raw = cycle_q;
        RegScratch: begin
          rd_raw   = scratch_q;
          rd_merge = 1'b1;
        end
        RegNone:   rd_raw = '0;
        default:   rd_raw = '0;
      endcase
    end else if (rd_ram_ok) begin
      rd_raw   = mem[rd_idx];
      rd_merge = 1'b1;
    end
    rd_val = rd_merge ? merge(rd_raw, bus.dat_wd, bus.dat_we) : rd_raw;
    rd_d   = (bus.dat_re != 4'h0) ? (rd_val & lane_mask(bus.dat_re)) : rd_q;
  end

  always_comb begin
    tohost_d  = wr_tohost  ? merge(tohost_q, wr_wd, wr_we)  : tohost_q;
    scratch_d = wr_scratch ? merge(scratch_q, wr_wd, wr_we) : scratch_q;
    done_d    = done_q | wr_tohost;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q      <= '0;
      tohost_q  <= '0;
      scratch_q <= '0;
      cycle_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      tohost_q  <= tohost_d;
      scratch_q <= scratch_d;
      cycle_q   <= cycle_q + 32'd1;
      done_q    <= done_d;
    end
  end

  assign bus.dat_rd   = rd_q;
  assign bus.ld_ready = ld_ready;
  assign bus.done     = done_q;
  assign bus.tohost   = tohost_q;

endmodule

// File: tb/tb_u_dmem.sv
// Self-checking bench for u_dmem: read results are queued when requested and compared
// one cycle later; status outputs are compared against constants inline.
module tb_u_dmem;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] sb_q[$];
  logic [31:0] exp;

  u_dmem_if bus ();

  u_dmem #(.DEPTH(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_core(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                          input logic [3:0] re);
    bus.dat_a  = a;
    bus.dat_we = we;
    bus.dat_wd = wd;
    bus.dat_re = re;
  endtask

  task automatic idle();
    set_core(16'h0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.dat_rd !== 32'h0) begin
      failures++; $display("FAIL reset_dat_rd got=%h exp=%h", bus.dat_rd, 32'h0);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b exp=0", bus.done);
    end
    checks++;
    if (bus.tohost !== 32'h0) begin
      failures++; $display("FAIL reset_tohost got=%h exp=%h", bus.tohost, 32'h0);
    end
    checks++;
    if (bus.ld_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ld_ready got=%b exp=0", bus.ld_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b1) begin
      failures++; $display("FAIL idle_ld_ready got=%b exp=1", bus.ld_ready);
    end
    tick();
  endtask

  task automatic test_ram_lanes();
    set_core(16'h0010, 4'hF, 32'hDEADBEEF, 4'h0); tick();
    set_core(16'h0010, 4'b0010, 32'h0000AA00, 4'h0); tick();
    set_core(16'h0010, 4'h0, 32'h0, 4'hF); sb_q.push_back(32'hDEADAAEF); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL lanes_full got=%h exp=%h", bus.dat_rd, exp);
    end
    set_core(16'h0010, 4'h0, 32'h0, 4'b1100); sb_q.push_back(32'hDEAD0000); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL lanes_upper got=%h exp=%h", bus.dat_rd, exp);
    end
    idle();
  endtask

  task automatic test_write_first_hold();
    set_core(16'h0020, 4'hF, 32'h12345678, 4'hF); sb_q.push_back(32'h12345678); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL write_first got=%h exp=%h", bus.dat_rd, exp);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick(); checks++;
      if (bus.dat_rd !== 32'h12345678) begin
        failures++; $display("FAIL hold_%0d got=%h exp=%h", i, bus.dat_rd, 32'h12345678);
      end
    end
    // Partial write plus partial read of the same word in one cycle.
    set_core(16'h0020, 4'b0001, 32'h000000AB, 4'b0011); sb_q.push_back(32'h000056AB); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL write_first_partial got=%h exp=%h", bus.dat_rd, exp);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      set_core(16'h0200 + 16'(4 * i), 4'hF, 32'hA0B0C000 + 32'(i), 4'h0); tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_core(16'h0200 + 16'(4 * i), 4'h0, 32'h0, 4'hF);
      sb_q.push_back(32'hA0B0C000 + 32'(i));
      tick();
      exp = sb_q.pop_front(); checks++;
      if (bus.dat_rd !== exp) begin
        failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, bus.dat_rd, exp);
      end
    end
    idle();
  endtask

  task automatic test_cycle();
    idle();
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (10) tick();
    set_core(16'hF004, 4'h0, 32'h0, 4'hF); sb_q.push_back(32'd10); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL cycle_10 got=%h exp=%h", bus.dat_rd, exp);
    end
    set_core(16'hF004, 4'hF, 32'hFFFFFFFF, 4'h0); tick();
    set_core(16'hF004, 4'h0, 32'h0, 4'hF); sb_q.push_back(32'd12); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL cycle_write_ignored got=%h exp=%h", bus.dat_rd, exp);
    end
    idle();
  endtask

  task automatic test_mmio();
    set_core(16'hF000, 4'hF, 32'h00000001, 4'h0);
    #1; checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL done_early got=%b exp=0", bus.done);
    end
    tick(); checks++;
    if (bus.done !== 1'b1) begin
      failures++; $display("FAIL done_set got=%b exp=1", bus.done);
    end
    checks++;
    if (bus.tohost !== 32'h1) begin
      failures++; $display("FAIL tohost_write got=%h exp=%h", bus.tohost, 32'h1);
    end
    set_core(16'hF008, 4'hF, 32'hA5A5A5A5, 4'h0); tick();
    set_core(16'hF008, 4'b1000, 32'h3C000000, 4'h0); tick();
    // 0xF018 aliases SCRATCH since bits [11:4] are not decoded.
    set_core(16'hF018, 4'h0, 32'h0, 4'hF); sb_q.push_back(32'h3CA5A5A5); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL scratch_merge got=%h exp=%h", bus.dat_rd, exp);
    end
    set_core(16'hF00C, 4'hF, 32'hFFFFFFFF, 4'hF); sb_q.push_back(32'h0); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL mmio_hole got=%h exp=%h", bus.dat_rd, exp);
    end
    set_core(16'hF000, 4'b0100, 32'h00770000, 4'hF); sb_q.push_back(32'h00770001); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL tohost_write_first got=%h exp=%h", bus.dat_rd, exp);
    end
    checks++;
    if (bus.tohost !== 32'h00770001) begin
      failures++; $display("FAIL tohost_merge got=%h exp=%h", bus.tohost, 32'h00770001);
    end
    // Reset wins over a same-cycle TOHOST write and discards the read.
    set_core(16'hF000, 4'hF, 32'h5, 4'hF); rst = 1'b1; sb_q.push_back(32'h0); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL rst_discard_read got=%h exp=%h", bus.dat_rd, exp);
    end
    checks++;
    if (bus.done !== 1'b0 || bus.tohost !== 32'h0) begin
      failures++;
      $display("FAIL rst_clear done=%b tohost=%h exp done=0 tohost=0", bus.done, bus.tohost);
    end
    rst = 1'b0;
    set_core(16'hF008, 4'h0, 32'h0, 4'hF); sb_q.push_back(32'h0); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL scratch_reset got=%h exp=%h", bus.dat_rd, exp);
    end
    idle();
  endtask

  task automatic test_loader();
    set_core(16'h0100, 4'hF, 32'h11111111, 4'h0); tick();
    bus.ld_valid = 1'b1; bus.ld_a = 16'h0100; bus.ld_wd = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      set_core(16'h0010, 4'h0, 32'h0, 4'hF); sb_q.push_back(32'hDEADAAEF);
      #1; checks++;
      if (bus.ld_ready !== 1'b0) begin
        failures++; $display("FAIL ld_blocked_%0d got=%b exp=0", i, bus.ld_ready);
      end
      tick();
      exp = sb_q.pop_front(); checks++;
      if (bus.dat_rd !== exp) begin
        failures++; $display("FAIL ld_core_read_%0d got=%h exp=%h", i, bus.dat_rd, exp);
      end
    end
    set_core(16'h0100, 4'h0, 32'h0, 4'hF); sb_q.push_back(32'h11111111); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL ld_no_write got=%h exp=%h", bus.dat_rd, exp);
    end
    idle();
    #1; checks++;
    if (bus.ld_ready !== 1'b1) begin
      failures++; $display("FAIL ld_ready_idle got=%b exp=1", bus.ld_ready);
    end
    tick();
    bus.ld_valid = 1'b0;
    set_core(16'h0100, 4'h0, 32'h0, 4'hF); sb_q.push_back(32'hCAFEF00D); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL ld_write got=%h exp=%h", bus.dat_rd, exp);
    end
    idle();
    bus.ld_valid = 1'b1; bus.ld_a = 16'hF000; bus.ld_wd = 32'hABCD0123; tick();
    bus.ld_valid = 1'b0;
    checks++;
    if (bus.tohost !== 32'hABCD0123 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL ld_tohost tohost=%h done=%b exp tohost=abcd0123 done=1",
               bus.tohost, bus.done);
    end
  endtask

  task automatic test_out_of_range();
    set_core(16'h0000, 4'hF, 32'h600DF00D, 4'h0); tick();
    set_core(16'h4000, 4'hF, 32'hFFFFFFFF, 4'h0); tick();
    set_core(16'h4000, 4'h0, 32'h0, 4'hF); sb_q.push_back(32'h0); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL oor_read got=%h exp=%h", bus.dat_rd, exp);
    end
    set_core(16'h0000, 4'h0, 32'h0, 4'hF); sb_q.push_back(32'h600DF00D); tick();
    exp = sb_q.pop_front(); checks++;
    if (bus.dat_rd !== exp) begin
      failures++; $display("FAIL oor_no_alias got=%h exp=%h", bus.dat_rd, exp);
    end
    idle();
  endtask

  task automatic test_cycle_wrap();
    set_core(16'hF004, 4'h0, 32'h0, 4'hF);
    force dut.cycle_q = 32'hFFFFFFFE;
    #1;
    release dut.cycle_q;
    sb_q.push_back(32'hFFFFFFFE);
    sb_q.push_back(32'hFFFFFFFF);
    sb_q.push_back(32'h00000000);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = sb_q.pop_front(); checks++;
      if (bus.dat_rd !== exp) begin
        failures++; $display("FAIL cycle_wrap_%0d got=%h exp=%h", i, bus.dat_rd, exp);
      end
    end
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    bus.ld_valid = 1'b0;
    bus.ld_a     = 16'h0;
    bus.ld_wd    = 32'h0;
    tick();
    test_reset();
    test_ram_lanes();
    test_write_first_hold();
    test_back_to_back();
    test_cycle();
    test_mmio();
    test_loader();
    test_out_of_range();
    test_cycle_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
